// File: rtl/arbiter_round_robin_if.sv
// Requester/resource handshake bundle for the round-robin arbiter.
// master drives requests, last flags and ready; slave (the arbiter) returns the grant.
interface arbiter_round_robin_if #(
  parameter int WIDTH = 8
);
  localparam int WIDTH_LOG = $clog2(WIDTH);

  logic [WIDTH-1:0]     req;
  logic [WIDTH-1:0]     lst;
  logic                 rdy;
  logic [WIDTH-1:0]     gnt;
  logic [WIDTH_LOG-1:0] gnt_idx;
  logic                 gnt_vld;
  logic                 trn;

  modport master (
    output req,
    output lst,
    output rdy,
    input  gnt,
    input  gnt_idx,
    input  gnt_vld,
    input  trn
  );

  modport slave (
    input  req,
    input  lst,
    input  rdy,
    output gnt,
    output gnt_idx,
    output gnt_vld,
    output trn
  );
endinterface

// File: rtl/arbiter_round_robin.sv
// Round-robin arbiter: registered one-hot grant (1-cycle latency), held across a multi-beat
// transfer; rdy low stalls the grant indefinitely, release re-arbitrates with no idle bubble.
module arbiter_round_robin #(
  parameter int WIDTH     = 8,
  parameter int MAX_BEATS = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  arbiter_round_robin_if.slave  bus
);
  localparam int WIDTH_LOG = $clog2(WIDTH);
  localparam int CNT_W     = (MAX_BEATS > 0) ? $clog2(MAX_BEATS + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((MAX_BEATS > 0) ? MAX_BEATS - 1 : 0);

  logic [WIDTH-1:0]     gnt_q;
  logic [WIDTH_LOG-1:0] gnt_idx_q;
  logic                 gnt_vld_q;
  logic [WIDTH_LOG-1:0] ptr_q;
  logic [CNT_W-1:0]     cnt_q;

  logic [WIDTH-1:0]     gnt_d;
  logic [WIDTH_LOG-1:0] gnt_idx_d;
  logic                 gnt_vld_d;
  logic [WIDTH_LOG-1:0] ptr_d;
  logic [CNT_W-1:0]     cnt_d;

  logic [WIDTH-1:0]     mask;
  logic                 msk_hit;
  logic [WIDTH_LOG-1:0] msk_idx;
  logic                 raw_hit;
  logic [WIDTH_LOG-1:0] raw_idx;
  logic [WIDTH_LOG-1:0] win_idx;
  logic                 trn;
  logic                 rel_lst;
  logic                 rel_lim;
  logic                 rel_wdr;
  logic                 release_evt;
  logic                 arb;

  // Lowest-index-wins encoder; returns {hit, index}.
  function automatic logic [WIDTH_LOG:0] lowest(input logic [WIDTH-1:0] vec);
    logic [WIDTH_LOG:0] res;
    res = '0;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (vec[i]) begin
        res = {1'b1, WIDTH_LOG'(i)};
      end
    end
    return res;
  endfunction

  always_comb begin
    mask = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (i > int'(ptr_q)) begin
        mask[i] = 1'b1;
      end
    end
    {msk_hit, msk_idx} = lowest(bus.req & mask);
    {raw_hit, raw_idx} = lowest(bus.req);
  end

  // A masked hit is always also a raw hit, so raw_hit alone says whether anyone wins.
  assign win_idx = msk_hit ? msk_idx : raw_idx;

  assign trn         = gnt_vld_q & bus.rdy;
  assign rel_lst     = trn & bus.lst[gnt_idx_q];
  assign rel_lim     = (MAX_BEATS != 0) && trn && (cnt_q == CNT_LAST);
  assign rel_wdr     = ~bus.req[gnt_idx_q];
  assign release_evt = gnt_vld_q & (rel_lst | rel_lim | rel_wdr);
  assign arb         = ~gnt_vld_q | release_evt;

  always_comb begin
    gnt_d     = gnt_q;
    gnt_idx_d = gnt_idx_q;
    gnt_vld_d = gnt_vld_q;
    ptr_d     = ptr_q;
    cnt_d     = cnt_q;
    if (arb) begin
      if (raw_hit) begin
        gnt_d     = WIDTH'(1) << win_idx;
        gnt_idx_d = win_idx;
        gnt_vld_d = 1'b1;
        ptr_d     = win_idx;
        cnt_d     = '0;
      end else begin
        gnt_d     = '0;
        gnt_vld_d = 1'b0;
      end
    end else if (trn && (MAX_BEATS != 0)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // ptr resets to the top index so requester 0 sees first priority.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      gnt_q     <= '0;
      gnt_idx_q <= '0;
      gnt_vld_q <= 1'b0;
      ptr_q     <= WIDTH_LOG'(WIDTH - 1);
      cnt_q     <= '0;
    end else begin
      gnt_q     <= gnt_d;
      gnt_idx_q <= gnt_idx_d;
      gnt_vld_q <= gnt_vld_d;
      ptr_q     <= ptr_d;
      cnt_q     <= cnt_d;
    end
  end

  assign bus.gnt     = gnt_q;
  assign bus.gnt_idx = gnt_idx_q;
  assign bus.gnt_vld = gnt_vld_q;
  assign bus.trn     = trn;

  a_gnt_consistent: assert property (@(posedge clk) disable iff (rst)
    gnt_q == (WIDTH'(gnt_vld_q) << gnt_idx_q));
  a_gnt_onehot: assert property (@(posedge clk) disable iff (rst) $onehot0(gnt_q));
endmodule

// File: tb/tb_arbiter_round_robin.sv
// Self-checking bench: unlimited-beat and MAX_BEATS=4 arbiters driven in lockstep.
module tb_arbiter_round_robin;
  localparam int W = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  arbiter_round_robin_if #(.WIDTH(W)) bus_a();
  arbiter_round_robin_if #(.WIDTH(W)) bus_b();

  arbiter_round_robin #(.WIDTH(W), .MAX_BEATS(0)) dut_a (.clk(clk), .rst(rst), .bus(bus_a));
  arbiter_round_robin #(.WIDTH(W), .MAX_BEATS(4)) dut_b (.clk(clk), .rst(rst), .bus(bus_b));

  typedef struct {
    int         dut;
    string      tag;
    logic [7:0] gnt;
    logic [2:0] idx;
    logic       vld;
    logic       trn;
  } exp_t;

  typedef struct {
    logic       do_rst;
    logic [7:0] req;
    logic [7:0] lst;
    logic       rdy;
    logic [7:0] gnt;
    logic [2:0] idx;
    logic       vld;
    logic       trn;
  } vec_t;

  typedef struct {
    logic       vld;
    logic [2:0] idx;
    logic [2:0] ptr;
    int         cnt;
  } m_t;

  exp_t sbq[$];
  vec_t tbl[$];
  int   errors = 0;
  int   checks = 0;
  m_t   ma, mb;

  task automatic cmp(string name, logic [31:0] act, logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic drive(logic [7:0] r, logic [7:0] l, logic rd);
    @(negedge clk);
    bus_a.req = r; bus_a.lst = l; bus_a.rdy = rd;
    bus_b.req = r; bus_b.lst = l; bus_b.rdy = rd;
  endtask

  task automatic expect_out(int dut, string tag, logic [7:0] g, logic [2:0] i, logic v, logic t);
    exp_t e;
    e.dut = dut; e.tag = tag; e.gnt = g; e.idx = i; e.vld = v; e.trn = t;
    sbq.push_back(e);
  endtask

  task automatic expect_both(string tag, logic [7:0] g, logic [2:0] i, logic v, logic t);
    expect_out(0, tag, g, i, v, t);
    expect_out(1, tag, g, i, v, t);
  endtask

  task automatic sample();
    exp_t e;
    logic [7:0] ag;
    logic [2:0] ai;
    logic av, at;
    string p;
    #1;
    while (sbq.size() > 0) begin
      e = sbq.pop_front();
      if (e.dut == 0) begin
        ag = bus_a.gnt; ai = bus_a.gnt_idx; av = bus_a.gnt_vld; at = bus_a.trn; p = "a:";
      end else begin
        ag = bus_b.gnt; ai = bus_b.gnt_idx; av = bus_b.gnt_vld; at = bus_b.trn; p = "b:";
      end
      cmp({p, e.tag, "/gnt"}, 32'(ag), 32'(e.gnt));
      cmp({p, e.tag, "/gnt_idx"}, 32'(ai), 32'(e.idx));
      cmp({p, e.tag, "/gnt_vld"}, 32'(av), 32'(e.vld));
      cmp({p, e.tag, "/trn"}, 32'(at), 32'(e.trn));
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    bus_a.req = '0; bus_a.lst = '0; bus_a.rdy = 1'b1;
    bus_b.req = '0; bus_b.lst = '0; bus_b.rdy = 1'b1;
    expect_both("reset", 8'h00, 3'd0, 1'b0, 1'b0);
    sample();
    @(negedge clk);
    rst = 1'b0;
    ma = '{vld: 1'b0, idx: 3'd0, ptr: 3'd7, cnt: 0};
    mb = ma;
  endtask

  // Reference: scan upward from the pointer, wrapping, so the last winner comes last.
  function automatic m_t mstep(m_t m, logic [7:0] r, logic [7:0] l, logic rd, int maxb);
    m_t   n;
    logic t, rel, found;
    int   c;
    n = m;
    t = m.vld & rd;
    if (!m.vld) rel = 1'b1;
    else rel = (t && l[m.idx]) || (t && maxb != 0 && m.cnt == maxb - 1) || !r[m.idx];
    if (rel) begin
      found = 1'b0;
      for (int k = 1; k <= W; k++) begin
        c = (int'(m.ptr) + k) % W;
        if (!found && r[c]) begin
          found = 1'b1;
          n.vld = 1'b1; n.idx = 3'(c); n.ptr = 3'(c); n.cnt = 0;
        end
      end
      if (!found) n.vld = 1'b0;
    end else if (t) begin
      n.cnt = m.cnt + 1;
    end
    return n;
  endfunction

  function automatic logic [7:0] onehot(logic [2:0] i);
    logic [7:0] one;
    one = 8'd1;
    return one << i;
  endfunction

  initial begin
    vec_t v;
    logic [7:0] r, l;
    logic rd;
    logic [2:0] ei;
    logic rdy_pat [9];

    bus_a.req = '0; bus_a.lst = '0; bus_a.rdy = 1'b1;
    bus_b.req = '0; bus_b.lst = '0; bus_b.rdy = 1'b1;

    // Single grant to requester 2, then idle with index held.
    v = '{1'b1, 8'h04, 8'h04, 1'b1, 8'h00, 3'd0, 1'b0, 1'b0}; tbl.push_back(v);
    v = '{1'b0, 8'h00, 8'h04, 1'b1, 8'h04, 3'd2, 1'b1, 1'b1}; tbl.push_back(v);
    v = '{1'b0, 8'h00, 8'h04, 1'b1, 8'h00, 3'd2, 1'b0, 1'b0}; tbl.push_back(v);
    // Full rotation 0..7,0 with no bubble.
    v = '{1'b1, 8'hFF, 8'hFF, 1'b1, 8'h00, 3'd0, 1'b0, 1'b0}; tbl.push_back(v);
    for (int k = 0; k < 9; k++) begin
      v.do_rst = 1'b0; v.req = 8'hFF; v.lst = 8'hFF; v.rdy = 1'b1;
      v.idx = 3'(k % 8); v.gnt = onehot(v.idx); v.vld = 1'b1; v.trn = 1'b1;
      tbl.push_back(v);
    end

    #12;
    expect_both("por", 8'h00, 3'd0, 1'b0, 1'b0);
    sample();
    rst = 1'b0;

    for (int n = 0; n < tbl.size(); n++) begin
      if (tbl[n].do_rst) do_reset();
      drive(tbl[n].req, tbl[n].lst, tbl[n].rdy);
      expect_both($sformatf("tbl%0d", n), tbl[n].gnt, tbl[n].idx, tbl[n].vld, tbl[n].trn);
      sample();
    end

    // Beat limit of 4 alternating between requesters 0 and 1.
    do_reset();
    for (int c = 0; c < 13; c++) begin
      drive(8'h03, 8'h00, 1'b1);
      if (c == 0) expect_out(1, "mb4", 8'h00, 3'd0, 1'b0, 1'b0);
      else begin
        ei = 3'(((c - 1) / 4) % 2);
        expect_out(1, $sformatf("mb4_%0d", c), onehot(ei), ei, 1'b1, 1'b1);
      end
      sample();
    end

    // Stalled beats do not count toward the limit.
    rdy_pat = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    do_reset();
    for (int c = 0; c < 9; c++) begin
      drive(8'h03, 8'h00, rdy_pat[c]);
      if (c == 0) expect_out(1, "stall", 8'h00, 3'd0, 1'b0, 1'b0);
      else begin
        ei = (c == 8) ? 3'd1 : 3'd0;
        expect_out(1, $sformatf("stall_%0d", c), onehot(ei), ei, 1'b1, rdy_pat[c]);
      end
      sample();
    end

    // Requester 5 held through a long stall, then withdraws: wrap to 0.
    do_reset();
    drive(8'h20, 8'h00, 1'b0);
    expect_both("hold5_0", 8'h00, 3'd0, 1'b0, 1'b0); sample();
    for (int c = 0; c < 10; c++) begin
      drive(8'h23, 8'h00, 1'b0);
      expect_both($sformatf("hold5_%0d", c + 1), 8'h20, 3'd5, 1'b1, 1'b0); sample();
    end
    drive(8'h03, 8'h00, 1'b0);
    expect_both("wdr5", 8'h20, 3'd5, 1'b1, 1'b0); sample();
    drive(8'h03, 8'h00, 1'b0);
    expect_both("wrap0", 8'h01, 3'd0, 1'b1, 1'b0); sample();

    // Sole requester 3 re-granted each beat, then requester 1 joins.
    do_reset();
    drive(8'h08, 8'h08, 1'b1);
    expect_both("solo_0", 8'h00, 3'd0, 1'b0, 1'b0); sample();
    for (int c = 1; c < 5; c++) begin
      drive(8'h08, 8'h08, 1'b1);
      expect_both($sformatf("solo_%0d", c), 8'h08, 3'd3, 1'b1, 1'b1); sample();
    end
    drive(8'h0A, 8'h0A, 1'b1);
    expect_both("join_3", 8'h08, 3'd3, 1'b1, 1'b1); sample();
    drive(8'h0A, 8'h0A, 1'b1);
    expect_both("join_1", 8'h02, 3'd1, 1'b1, 1'b1); sample();
    drive(8'h0A, 8'h0A, 1'b1);
    expect_both("join_3b", 8'h08, 3'd3, 1'b1, 1'b1); sample();

    // Asynchronous reset mid-transfer, then requester 0 wins first.
    do_reset();
    drive(8'h40, 8'h00, 1'b1);
    expect_both("mid_0", 8'h00, 3'd0, 1'b0, 1'b0); sample();
    drive(8'h40, 8'h00, 1'b1);
    expect_both("mid_1", 8'h40, 3'd6, 1'b1, 1'b1); sample();
    drive(8'h40, 8'h00, 1'b1);
    expect_both("mid_2", 8'h40, 3'd6, 1'b1, 1'b1); sample();
    @(negedge clk);
    #2 rst = 1'b1;
    expect_both("async_rst", 8'h00, 3'd0, 1'b0, 1'b0); sample();
    @(negedge clk);
    rst = 1'b0;
    bus_a.req = '0; bus_b.req = '0;
    drive(8'h41, 8'h00, 1'b1);
    expect_both("post_0", 8'h00, 3'd0, 1'b0, 1'b0); sample();
    drive(8'h41, 8'h41, 1'b1);
    expect_both("post_1", 8'h01, 3'd0, 1'b1, 1'b1); sample();
    drive(8'h41, 8'h41, 1'b1);
    expect_both("post_2", 8'h40, 3'd6, 1'b1, 1'b1); sample();

    // Random traffic against the reference model.
    do_reset();
    for (int c = 0; c < 400; c++) begin
      r  = ($urandom_range(0, 7) == 0) ? 8'h00 : (8'($urandom) | 8'($urandom));
      l  = 8'($urandom) & 8'($urandom);
      rd = ($urandom_range(0, 3) != 0);
      drive(r, l, rd);
      expect_out(0, $sformatf("rnd%0d", c), ma.vld ? onehot(ma.idx) : 8'h00, ma.idx, ma.vld,
                 ma.vld & rd);
      expect_out(1, $sformatf("rnd%0d", c), mb.vld ? onehot(mb.idx) : 8'h00, mb.idx, mb.vld,
                 mb.vld & rd);
      sample();
      ma = mstep(ma, r, l, rd, 0);
      mb = mstep(mb, r, l, rd, 4);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/arbiter_round_robin.md
# arbiter_round_robin

Round-robin arbiter that shares one downstream resource among `WIDTH` requesters. A rotating-priority selection is built from two lowest-index-wins priority encoders, one over masked requests and one over unmasked. A registered one-hot grant is held for a multi-beat transfer, with an optional beat limit per grant. It sits between requester ports and a shared resource, such as a bus master port or memory port, that accepts beats with a ready handshake.

## Interface
Parameters:
- `WIDTH`, default 8: number of requesters; must be at least 2.
- `MAX_BEATS`, default 0: maximum transfer beats per grant; 0 means unlimited.
- `WIDTH_LOG`, localparam, `$clog2(WIDTH)`: grant index width.
- `CNT_W`, localparam, `$clog2(MAX_BEATS+1)`, minimum 1: beat counter width.

Ports:
- `clk`  in  1  clock.
- `rst`  in  1  reset, asynchronous and active-high.
- `req`  in  `WIDTH`  per-requester request, level.
- `lst`  in  `WIDTH`  per-requester last-beat flag; only the bit at `gnt_idx` is used.
- `rdy`  in  1  shared resource ready to accept a beat.
- `gnt`  out  `WIDTH`  one-hot grant, registered.
- `gnt_idx`  out  `WIDTH_LOG`  binary index of the granted requester, registered.
- `gnt_vld`  out  1  a grant is active, registered.
- `trn`  out  1  a beat transfers this cycle; `trn = gnt_vld & rdy`, combinational.

## Operation
- Two states: IDLE (`gnt_vld=0`) and BUSY (`gnt_vld=1`). The state is exactly `gnt_vld`; no separate FSM register.
- Priority pointer `ptr`, `WIDTH_LOG` bits, holds the index of the last granted requester.
  - Mask = bits strictly above `ptr`.
  - If `req & mask` is nonzero, pick its lowest set index.
  - Otherwise pick the lowest set index of `req`.
- Arbitration event (`arb`): the state is IDLE, or the state is BUSY and a release occurs this cycle.
- Release in BUSY occurs when any of the following holds:
  - (a) `trn & lst[gnt_idx]`.
  - (b) `trn` and `MAX_BEATS!=0` and `cnt==MAX_BEATS-1`.
  - (c) `!req[gnt_idx]`: withdrawal with no transfer; if `trn` is also set, the beat still counts.
- On `arb`:
  - If a winner exists: `gnt` gets one-hot(winner), `gnt_idx` gets winner, `gnt_vld` gets 1, `ptr` gets winner, `cnt` gets 0.
  - If no winner: `gnt` gets 0, `gnt_vld` gets 0; `ptr` and `gnt_idx` hold.
- In BUSY without release: outputs hold, and `cnt` increments on each `trn`.
- Winner selection during a release uses the current `ptr`, i.e. the releasing requester. That requester has lowest priority and is re-granted only if it is the sole requester.
- Requests not at `gnt_idx` never affect the current grant; no preemption.
- `cnt` saturates logically via release (b). When `MAX_BEATS=0`, `cnt` is unused and may be optimized out.
- `gnt` is always one-hot or zero, and `gnt == (gnt_vld << gnt_idx)`.

## Timing
- Reset values: `gnt=0`, `gnt_idx=0`, `gnt_vld=0`, `ptr=WIDTH-1` (requester 0 has top priority first), `cnt=0`. `trn=0` while in reset since `gnt_vld=0`.
- Reset is asynchronous and takes effect immediately mid-transfer; the grant drops without a release.
- Grant latency: `req` sampled high in IDLE at edge N gives `gnt_vld=1` after edge N, i.e. one cycle.
- Back-to-back: release at edge M with other pending requests gives the new grant valid after edge M. No idle bubble between grants.
- `rdy` low stalls the grant indefinitely; the grant holds, `cnt` holds.
- `trn` follows `rdy` combinationally within the cycle; no internal `rdy`-to-`rdy` path.
- Release (a), (b) and (c) in the same cycle are a single release.

## Test plan
- Reset then `req=8'b0000_0100`, `rdy=1`, `lst[2]=1` at the first beat: cycle 1 `gnt=8'h04`, `gnt_idx=2`, `trn=1`; cycle 2 `gnt_vld=0`.
- `req=8'hFF` steady, `lst` all 1, `rdy=1`: grants rotate 0,1,2,…,7,0 one per cycle with no bubble.
- `MAX_BEATS=4`, `req=8'h03`, `lst=0`, `rdy=1`: requester 0 holds for exactly 4 `trn` cycles, then requester 1 for 4, then back to 0.
- Grant to requester 5 with `rdy=0` for 10 cycles: `gnt` stable at `8'h20`, `cnt` stays 0; requester 5 drops `req` → next cycle grants the lowest pending index above 5, wrapping to 0.
- Only requester 3 requesting, `lst[3]=1` every beat: re-granted every cycle (`gnt_idx=3` continuous); then requester 1 raises `req` → requester 1 granted right after the next release of 3.
- Assert `rst` mid-transfer (`gnt_idx=6`, `cnt=2`): outputs go to reset values immediately; after deassert with `req=8'h41`, requester 0 is granted first.
